instr_fetch_unit: RTL and testbench

- Pipeline IF stage, directly upstream of the instruction side of cache_container.
- Owns the PC and drives iaddr/iren.
- Holds each request stable across I-cache misses and captures idata on idata_ready into a one-entry IF/ID output register.
- Handles downstream stall, branch redirect (including a redirect while a miss is outstanding) and HLT.

---
 rtl/instr_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, issues I-cache reads, and holds one fetched instruction
// in an IF/ID register until decode accepts it. Handles stall, redirect and HLT.
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [15:0] PC_STEP     = 16'd2,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_in,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] iaddr,
   output logic        iren,
   input  logic [15:0] idata,
   input  logic        idata_ready,
   output logic [15:0] inst_out,
   output logic [15:0] pc_out,
   output logic [15:0] pc_plus2_out,
   output logic        inst_valid,
   output logic        fetch_stall
);

   // Handshakes: the I-cache request is iren/iaddr, answered by idata_ready (same
   // cycle on a hit, later on a miss; iren/iaddr are frozen until then). Decode
   // takes the output register on a cycle with inst_valid=1 and stall_in=0.

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t      state, state_nx;
   logic [15:0] pc, pc_nx;
   logic [15:0] target, target_nx;
   logic        busy, busy_nx;
   logic        squash, squash_nx;
   logic [15:0] inst_nx, pc_out_nx, pc_plus2_nx;
   logic        valid_nx;

   logic        accept;
   logic        resp;
   logic        is_halt;

   assign iaddr = pc;

   always_comb begin
      accept      = inst_valid & ~stall_in;
      iren        = ~rst & (busy | ((state == ST_RUN) & (~inst_valid | ~stall_in)));
      resp        = iren & idata_ready;
      fetch_stall = iren & ~idata_ready;
      is_halt     = (idata[15:12] == HALT_OPCODE);

      state_nx    = state;
      pc_nx       = pc;
      target_nx   = target;
      busy_nx     = busy;
      squash_nx   = squash;
      inst_nx     = inst_out;
      pc_out_nx   = pc_out;
      pc_plus2_nx = pc_plus2_out;
      valid_nx    = inst_valid;

      if (redirect) begin
         valid_nx = 1'b0;
         state_nx = ST_RUN;
         if (iren & ~idata_ready) begin
            // iaddr must stay frozen, so the target waits until the stale response returns
            busy_nx   = 1'b1;
            squash_nx = 1'b1;
            target_nx = redirect_pc;
         end else begin
            busy_nx   = 1'b0;
            squash_nx = 1'b0;
            pc_nx     = redirect_pc;
         end
      end else if (resp & squash) begin
         busy_nx   = 1'b0;
         squash_nx = 1'b0;
         pc_nx     = target;
         if (accept) begin
            valid_nx = 1'b0;
         end
      end else if (resp) begin
         inst_nx     = idata;
         pc_out_nx   = pc;
         pc_plus2_nx = pc + PC_STEP;
         valid_nx    = 1'b1;
         busy_nx     = 1'b0;
         if (is_halt) begin
            state_nx = ST_HALTED;
         end else begin
            pc_nx = pc + PC_STEP;
         end
      end else begin
         if (iren) begin
            busy_nx = 1'b1;
         end
         if (accept) begin
            valid_nx = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_RUN;
         pc           <= RESET_PC;
         target       <= RESET_PC;
         busy         <= 1'b0;
         squash       <= 1'b0;
         inst_out     <= 16'h0000;
         pc_out       <= 16'h0000;
         pc_plus2_out <= 16'h0000;
         inst_valid   <= 1'b0;
      end else begin
         state        <= state_nx;
         pc           <= pc_nx;
         target       <= target_nx;
         busy         <= busy_nx;
         squash       <= squash_nx;
         inst_out     <= inst_nx;
         pc_out       <= pc_out_nx;
         pc_plus2_out <= pc_plus2_nx;
         inst_valid   <= valid_nx;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: I-cache model with random latency, an instruction
// stream reference model, and a scoreboard of delivered {pc, inst} pairs.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, stall_in, redirect;
   logic [15:0] redirect_pc, iaddr, idata, inst_out, pc_out, pc_plus2_out;
   logic        iren, idata_ready, inst_valid, fetch_stall;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk          (clk),
      .rst          (rst),
      .stall_in     (stall_in),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .iaddr        (iaddr),
      .iren         (iren),
      .idata        (idata),
      .idata_ready  (idata_ready),
      .inst_out     (inst_out),
      .pc_out       (pc_out),
      .pc_plus2_out (pc_plus2_out),
      .inst_valid   (inst_valid),
      .fetch_stall  (fetch_stall)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   logic [15:0] mem [0:255];
   logic [31:0] exp_q [$];

   // reference model: architectural stream plus expected output register
   bit          m_init    = 1'b0;
   bit          m_valid   = 1'b0;
   bit          m_halted  = 1'b0;
   bit          m_busy    = 1'b0;
   logic [15:0] m_inst    = '0;
   logic [15:0] m_pc      = '0;
   logic [15:0] m_pc2     = '0;
   logic [15:0] m_wanted  = '0;
   logic [15:0] m_lock    = '0;
   int          epoch     = 0;
   int          req_epoch = 0;
   int          lat_cnt   = 0;
   int          lat_mode  = 0;

   function automatic logic [15:0] fetch_word(input logic [15:0] a);
      return mem[a[8:1]];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic s, input logic r, input logic [15:0] rp, input logic rs);
      logic        rdy, ex_iren, accept;
      logic [15:0] ex_addr, w;
      int          tag;
      @(negedge clk);
      rst         = rs;
      stall_in    = s;
      redirect    = r;
      redirect_pc = rp;
      idata_ready = 1'b0;
      idata       = 16'($urandom);
      #1;
      ex_iren = m_init && !rs && (m_busy || (!m_halted && (!m_valid || !s)));
      ex_addr = m_busy ? m_lock : m_wanted;
      rdy     = 1'b0;
      if (ex_iren) begin
         if (!m_busy) begin
            if (lat_mode >= 0) lat_cnt = lat_mode;
            else lat_cnt = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
         end
         if (lat_cnt == 0) rdy = 1'b1;
         else lat_cnt--;
      end
      idata_ready = rdy;
      if (rdy) idata = fetch_word(ex_addr);
      #1;
      if (m_init) begin
         check("iren", {31'd0, iren}, {31'd0, ex_iren});
         if (ex_iren) check("iaddr", {16'd0, iaddr}, {16'd0, ex_addr});
         check("fetch_stall", {31'd0, fetch_stall}, {31'd0, ex_iren & ~rdy});
         check("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
         check("inst_out", {16'd0, inst_out}, {16'd0, m_inst});
         check("pc_out", {16'd0, pc_out}, {16'd0, m_pc});
         check("pc_plus2_out", {16'd0, pc_plus2_out}, {16'd0, m_pc2});
      end
      // advance the model across the coming rising edge
      if (rs) begin
         m_init = 1'b1; m_valid = 1'b0; m_halted = 1'b0; m_busy = 1'b0;
         m_inst = '0; m_pc = '0; m_pc2 = '0; m_wanted = 16'h0000;
         epoch++;
         exp_q.delete();
      end else if (m_init) begin
         accept = m_valid && !s;
         if (r) begin
            if (ex_iren && !rdy) begin
               if (!m_busy) begin
                  m_busy = 1'b1; m_lock = ex_addr; req_epoch = epoch;
               end
            end else begin
               m_busy = 1'b0;
            end
            epoch++;
            m_valid = 1'b0; m_halted = 1'b0; m_wanted = rp;
         end else if (ex_iren && rdy) begin
            tag    = m_busy ? req_epoch : epoch;
            m_busy = 1'b0;
            if (tag == epoch) begin
               w = fetch_word(ex_addr);
               exp_q.push_back({ex_addr, w});
               m_valid = 1'b1; m_inst = w; m_pc = ex_addr; m_pc2 = ex_addr + 16'd2;
               if (w[15:12] == 4'hF) m_halted = 1'b1;
               else m_wanted = ex_addr + 16'd2;
            end else if (accept) begin
               m_valid = 1'b0;
            end
         end else begin
            if (ex_iren && !m_busy) begin
               m_busy = 1'b1; m_lock = ex_addr; req_epoch = epoch;
            end
            if (accept) m_valid = 1'b0;
         end
      end
   endtask

   // monitor: a fresh instruction in the output register must match the queue head
   initial begin
      logic        last_valid;
      logic [31:0] e;
      last_valid = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (m_init && inst_valid && !(last_valid && stall_in)) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL sb_unexpected: got pc %h inst %h expected none", pc_out, inst_out);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", {16'd0, pc_out}, {16'd0, e[31:16]});
               check("sb_inst", {16'd0, inst_out}, {16'd0, e[15:0]});
               check("sb_pc_plus2", {16'd0, pc_plus2_out}, {16'd0, e[31:16] + 16'd2});
            end
         end
         last_valid = inst_valid;
      end
   end

   initial begin
      logic [15:0] w;
      rst = 1'b1; stall_in = 1'b0; redirect = 1'b0; redirect_pc = '0;
      idata = '0; idata_ready = 1'b0;
      for (int i = 0; i < 256; i++) begin
         w = 16'($urandom);
         if (i < 64 || i >= 254) begin
            if (w[15:12] == 4'hF) w[15:12] = 4'hE;
         end else if ($urandom_range(0, 15) == 0) begin
            w[15:12] = 4'hF;
         end
         mem[i] = w;
      end
      mem[8'h20] = 16'hF000;

      lat_mode = 0;
      step(0, 0, 16'h0, 1);
      step(0, 0, 16'h0, 1);
      for (int i = 0; i < 8; i++) step(0, 0, 16'h0, 0);
      lat_mode = 4;
      step(0, 0, 16'h0, 0);
      lat_mode = 0;
      for (int i = 0; i < 4; i++) step(logic'(i % 2), 0, 16'h0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 0);
      step(0, 0, 16'h0, 0);
      step(0, 1, 16'h0020, 0);
      lat_mode = 6;
      step(0, 0, 16'h0, 0);
      lat_mode = 0;
      step(0, 1, 16'h0100, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 16'h0, 0);
      step(0, 1, 16'h0200, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0);
      step(0, 1, 16'h003C, 0);
      for (int i = 0; i < 8; i++) step(logic'(i == 5), 0, 16'h0, 0);
      step(0, 1, 16'h0080, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 0);
      step(0, 1, 16'hFFFC, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 16'h0, 0);

      lat_mode = -1;
      for (int i = 0; i < 3000; i++) begin
         step(logic'($urandom_range(0, 9) < 3),
              logic'($urandom_range(0, 19) == 0),
              {15'($urandom_range(0, 32767)), 1'b0},
              logic'($urandom_range(0, 499) == 0));
      end

      lat_mode = 0;
      for (int i = 0; i < 6; i++) step(0, 0, 16'h0, 0);
      @(posedge clk);
      #3;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
